// File: rtl/lim_inc_dec.sv
// One digit of a modulo-L counter chain: adds carry-in, subtracts borrow-in,
// wraps into [0, L-1] and registers the result with overflow/underflow flags.
module lim_inc_dec #(
   parameter int unsigned L = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic       ci,
   input  logic       cid,
   output logic [3:0] sum,
   output logic       overflow,
   output logic       underflow
);

   localparam logic signed [5:0] LimS = 6'(L);
   localparam logic [3:0]        DigMax = 4'(L - 1);

   logic signed [5:0] z;
   logic [3:0]        sum_d;
   logic              overflow_d;
   logic              underflow_d;

   // Zero-extend everything so the raw value stays signed in [-1, 16].
   always_comb begin
      z = $signed({2'b00, a}) + $signed({5'b00000, ci}) - $signed({5'b00000, cid});
      sum_d       = z[3:0];
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (z >= LimS) begin
         sum_d      = 4'd0;
         overflow_d = 1'b1;
      end else if (z < 6'sd0) begin
         sum_d       = DigMax;
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= 4'd0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         sum       <= sum_d;
         overflow  <= overflow_d;
         underflow <= underflow_d;
      end
   end

endmodule

// File: tb/tb_lim_inc_dec.sv
// Self-checking bench for lim_inc_dec: drives an L=10 and an L=16 instance with
// the same stimulus and compares both against an arithmetic reference model.
module tb_lim_inc_dec;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a;
   logic       ci;
   logic       cid;
   logic [3:0] sum10, sum16;
   logic       ovf10, ovf16, udf10, udf16;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lim_inc_dec #(.L(10)) dut10 (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .ci        (ci),
      .cid       (cid),
      .sum       (sum10),
      .overflow  (ovf10),
      .underflow (udf10)
   );

   lim_inc_dec #(.L(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .ci        (ci),
      .cid       (cid),
      .sum       (sum16),
      .overflow  (ovf16),
      .underflow (udf16)
   );

   // Reference: returns {overflow, underflow, sum[3:0]}.
   function automatic logic [5:0] model(input int l, input int av, input int c, input int b,
                                        input bit r);
      int zz;
      if (r) return 6'b0;
      zz = av + c - b;
      if (zz >= l) return {2'b10, 4'd0};
      if (zz < 0)  return {2'b01, 4'(l - 1)};
      return {2'b00, 4'(zz)};
   endfunction

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed ovf/udf/sum=%b/%b/%0d expected %b/%b/%0d", tag,
                obs[5], obs[4], obs[3:0], exp[5], exp[4], exp[3:0]);
      end
   endtask

   // Apply one operation, clock it in, then check both instances.
   task automatic step(input string tag, input bit r, input int av, input int c, input int b);
      rst = r;
      a   = 4'(av);
      ci  = c[0];
      cid = b[0];
      @(posedge clk);
      #1;
      check({tag, "_L10"}, {ovf10, udf10, sum10}, model(10, av, c, b, r));
      check({tag, "_L16"}, {ovf16, udf16, sum16}, model(16, av, c, b, r));
   endtask

   initial begin
      rst = 1'b1;
      a   = 4'd0;
      ci  = 1'b0;
      cid = 1'b0;
      @(negedge clk);

      // Reset with live data inputs, then release.
      step("reset0", 1, 7, 1, 0);
      step("reset1", 1, 7, 1, 0);
      step("release", 0, 7, 1, 0);
      n_checks++;
      assert (sum10 === 4'd8)
      else begin
         n_fail++;
         $error("FAIL release_sum: observed %0d expected 8", sum10);
      end

      // Normal range.
      step("inc4", 0, 4, 1, 0);
      step("dec4", 0, 4, 0, 1);
      step("cancel4", 0, 4, 1, 1);

      // Wrap up / wrap down / out-of-range inputs.
      step("wrap9", 0, 9, 1, 0);
      step("oor13", 0, 13, 0, 0);
      step("oor12dec", 0, 12, 0, 1);
      step("wrap15", 0, 15, 1, 0);
      step("under0", 0, 0, 0, 1);
      step("cancel0", 0, 0, 1, 1);

      // Mid-stream reset discards the cycle's inputs.
      step("midrst", 1, 9, 1, 0);
      step("postrst", 0, 3, 1, 0);

      // Exhaustive sweep.
      for (int i = 0; i < 64; i++) begin
         step("exh", 0, i >> 2, (i >> 1) & 1, i & 1);
      end

      // Back-to-back alternation; flags must not stick.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) step("b2b_ovf", 0, 9, 1, 0);
         else            step("b2b_clr", 0, 5, 0, 0);
         n_checks++;
         assert (ovf10 === ((i % 2 == 0) ? 1'b1 : 1'b0))
         else begin
            n_fail++;
            $error("FAIL b2b_toggle: observed %b at step %0d", ovf10, i);
         end
      end

      // Random operations, occasionally with reset.
      for (int i = 0; i < 200; i++) begin
         step("rand", ($urandom_range(0, 19) == 0), $urandom_range(0, 15),
              $urandom_range(0, 1), $urandom_range(0, 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
